// File: rtl/ps2_led_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the PS/2 Caps Lock LED sequencer.
// Keyboard command/reply bytes, LED bit positions and the sequencer FSM state type.
package ps2_led_ctrl_pkg;

    localparam logic [7:0] PS2_CMD_SETLED = 8'hED;
    localparam logic [7:0] PS2_ACK        = 8'hFA;
    localparam logic [7:0] PS2_RESEND     = 8'hFE;

    localparam int LED_CAPS   = 2;
    localparam int LED_NUM    = 1;
    localparam int LED_SCROLL = 0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND_CMD  = 3'd1,
        ST_WAIT_TX1  = 3'd2,
        ST_WAIT_ACK1 = 3'd3,
        ST_SEND_LED  = 3'd4,
        ST_WAIT_TX2  = 3'd5,
        ST_WAIT_ACK2 = 3'd6
    } state_t;

    // LED argument byte for the set-LED command; only Caps is mirrored.
    function automatic logic [7:0] led_byte(input logic caps);
        logic [7:0] b;
        b             = 8'h00;
        b[LED_CAPS]   = caps;
        b[LED_NUM]    = 1'b0;
        b[LED_SCROLL] = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/ps2_led_ctrl_timeout.sv
// ps2_timeout: reply watchdog for the LED sequencer.
// Counts enabled cycles and flags the cycle the count reaches TIMEOUT_CYCLES-1.
module ps2_timeout #(
    parameter int TIMEOUT_CYCLES = 2_500_000,
    parameter int TIMEOUT_W      = 22
) (
    input  logic clk,
    input  logic i_sclr,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_W-1:0] r_cnt;

    // Cycle counter: cleared when a new wait window opens, advances while waiting.
    always_ff @(posedge clk) begin
        if (i_sclr) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = i_en && (r_cnt == LAST);

endmodule

// File: rtl/ps2_led_ctrl.sv
// ps2_led_ctrl: mirrors Caps Lock to the keyboard LEDs with the ED <led> sequence.
// Optional macro PS2_LED_RETRY_EN enables bounded resend on FE replies.
module ps2_led_ctrl
    import ps2_led_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2_500_000,
    parameter int TIMEOUT_W      = 22
`ifdef PS2_LED_RETRY_EN
    ,
    parameter int MAX_RETRY      = 3
`endif
) (
    input  logic       clk,
    input  logic       i_sclr,
    input  logic       i_capslock,
    input  logic       i_byte_en,
    input  logic [7:0] i_byte,
    output logic       o_pass_en,
    output logic       o_tx_en,
    output logic [7:0] o_tx_byte,
    input  logic       i_tx_done,
    output logic       o_busy,
    output logic       o_err
);

    state_t     r_state;
    logic       r_tx_en;
    logic [7:0] r_tx_byte;
    logic       r_err;
    logic       r_pending;
    logic       r_led_q;

    logic       w_in_ack;
    logic       w_in_tx;
    logic       w_is_ack;
    logic       w_is_rsd;
    logic       w_timer_clr;
    logic       w_expire;

`ifdef PS2_LED_RETRY_EN
    localparam int RETRY_W = $clog2(MAX_RETRY + 2);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY);
    logic [RETRY_W-1:0] r_retry;
`endif

    assign w_in_ack = (r_state == ST_WAIT_ACK1) || (r_state == ST_WAIT_ACK2);
    assign w_in_tx  = (r_state == ST_WAIT_TX1) || (r_state == ST_WAIT_TX2);
    assign w_is_ack = i_byte_en && (i_byte == PS2_ACK);
    assign w_is_rsd = i_byte_en && (i_byte == PS2_RESEND);

    assign w_timer_clr = w_in_tx && i_tx_done;

    // Replies to our own commands are swallowed; everything else reaches the decoder.
    assign o_pass_en = i_byte_en && !(w_in_ack && (w_is_ack || w_is_rsd));

    assign o_tx_en   = r_tx_en;
    assign o_tx_byte = r_tx_byte;
    assign o_err     = r_err;
    assign o_busy    = (r_state != ST_IDLE);

    ps2_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_W      (TIMEOUT_W)
    ) u_timeout (
        .clk      (clk),
        .i_sclr   (i_sclr),
        .i_clr    (w_timer_clr),
        .i_en     (w_in_ack),
        .o_expire (w_expire)
    );

    // Sequencer: change detect, command/LED send, reply handling and timeout.
    always_ff @(posedge clk) begin
        if (i_sclr) begin
            r_state   <= ST_IDLE;
            r_tx_en   <= 1'b0;
            r_tx_byte <= 8'h00;
            r_err     <= 1'b0;
            r_pending <= 1'b0;
            r_led_q   <= 1'b0;
`ifdef PS2_LED_RETRY_EN
            r_retry   <= '0;
`endif
        end else begin
            r_tx_en <= 1'b0;
            r_err   <= 1'b0;
            if (i_capslock != r_led_q) begin
                r_pending <= 1'b1;
            end
            unique case (r_state)
                ST_IDLE: begin
                    if (r_pending) begin
                        r_led_q   <= i_capslock;
                        r_pending <= 1'b0;
                        r_tx_en   <= 1'b1;
                        r_tx_byte <= PS2_CMD_SETLED;
                        r_state   <= ST_SEND_CMD;
`ifdef PS2_LED_RETRY_EN
                        r_retry   <= '0;
`endif
                    end
                end
                ST_SEND_CMD: begin
                    r_state <= ST_WAIT_TX1;
                end
                ST_WAIT_TX1: begin
                    if (i_tx_done) begin
                        r_state <= ST_WAIT_ACK1;
                    end
                end
                ST_WAIT_ACK1: begin
                    if (w_is_ack) begin
                        r_tx_en   <= 1'b1;
                        r_tx_byte <= led_byte(r_led_q);
                        r_state   <= ST_SEND_LED;
`ifdef PS2_LED_RETRY_EN
                        r_retry   <= '0;
`endif
                    end else if (w_is_rsd) begin
`ifdef PS2_LED_RETRY_EN
                        if (r_retry == RETRY_LAST) begin
                            r_err   <= 1'b1;
                            r_retry <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_retry   <= r_retry + 1'b1;
                            r_tx_en   <= 1'b1;
                            r_tx_byte <= PS2_CMD_SETLED;
                            r_state   <= ST_SEND_CMD;
                        end
`else
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
`endif
                    end else if (w_expire) begin
                        r_err     <= 1'b1;
                        r_pending <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_SEND_LED: begin
                    r_state <= ST_WAIT_TX2;
                end
                ST_WAIT_TX2: begin
                    if (i_tx_done) begin
                        r_state <= ST_WAIT_ACK2;
                    end
                end
                ST_WAIT_ACK2: begin
                    if (w_is_ack) begin
                        r_state <= ST_IDLE;
`ifdef PS2_LED_RETRY_EN
                        r_retry <= '0;
`endif
                    end else if (w_is_rsd) begin
`ifdef PS2_LED_RETRY_EN
                        if (r_retry == RETRY_LAST) begin
                            r_err   <= 1'b1;
                            r_retry <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_retry   <= r_retry + 1'b1;
                            r_tx_en   <= 1'b1;
                            r_tx_byte <= led_byte(r_led_q);
                            r_state   <= ST_SEND_LED;
                        end
`else
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
`endif
                    end else if (w_expire) begin
                        r_err     <= 1'b1;
                        r_pending <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
